// File: rtl/pe_char_feeder.sv
// pe_char_feeder: sequencer between a character stream and a linear array of
// NUM_PE string-matching PEs.
//   Phase 1 (LOAD/WSET): pattern characters are shifted into the pat lanes and
//   presented with pe_alu_op=1 so the PEs latch them as weights.
//   Phase 2 (STREAM/DRAIN): text characters slide through the win lanes with
//   pe_alu_op=0. The AND of the PE compare bits one cycle after each accepted
//   character reports a match starting at match_pos.
// Ports:
//   clk, reset            clock, async active-high reset
//   start, pat_len        job request (sampled in IDLE only) and pattern length
//   in_valid/in_ready     character handshake; in_data, in_last (text end)
//   pe_alu_op, pe_en      PE control; pe_char lane k at [k*DWIDTH +: DWIDTH]
//   pe_match              PE compare results (1 when that lane's en is low)
//   match_valid/match_pos one-cycle match report, 0-based text index
//   busy, done, cfg_err   status; cfg_err pulses when start is rejected
// Optional build macro PE_FEEDER_MATCH_COUNT_EN adds output match_count, a
// saturating per-job count of reported matches.

module pe_char_feeder_lane #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              ld,
  input  logic              sh,
  input  logic              alu_op,
  input  logic              strobe,
  input  logic              active,
  input  logic [DWIDTH-1:0] pat_in,
  input  logic [DWIDTH-1:0] win_in,
  output logic [DWIDTH-1:0] pat_q,
  output logic [DWIDTH-1:0] win_q,
  output logic [DWIDTH-1:0] ch,
  output logic              en
);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pat_q <= '0;
      win_q <= '0;
    end else if (clr) begin
      pat_q <= '0;
      win_q <= '0;
    end else begin
      if (ld) pat_q <= pat_in;
      if (sh) win_q <= win_in;
    end

  assign ch = alu_op ? pat_q : win_q;
  assign en = strobe & active;
endmodule

module pe_char_feeder #(
  parameter int DWIDTH = 8,
  parameter int NUM_PE = 8,
  parameter int IDXW   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(NUM_PE):0]  pat_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DWIDTH-1:0]        in_data,
  input  logic                     in_last,
  output logic                     pe_alu_op,
  output logic [NUM_PE-1:0]        pe_en,
  output logic [NUM_PE*DWIDTH-1:0] pe_char,
  input  logic [NUM_PE-1:0]        pe_match,
  output logic                     match_valid,
  output logic [IDXW-1:0]          match_pos,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
`ifdef PE_FEEDER_MATCH_COUNT_EN
  ,
  output logic [IDXW-1:0]          match_count
`endif
);
  localparam int LW = $clog2(NUM_PE) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WSET, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [LW-1:0]   plen, lcnt;
  logic [IDXW-1:0] cnt;
  logic            strobe;
  logic            hs, start_ok;

  logic [NUM_PE-1:0][DWIDTH-1:0] pat_q, win_q, pat_nx, win_nx, ch;
  logic [NUM_PE-1:0]             active;

  assign hs       = in_valid & in_ready;
  assign start_ok = start && (pat_len != '0) && (pat_len <= LW'(NUM_PE));

  // ---- FSM: state register ----
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_IDLE;
    else       state <= state_nx;

  // ---- FSM: next state ----
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_ok) state_nx = S_LOAD;
      S_LOAD:   if (hs && (lcnt + LW'(1) == plen)) state_nx = S_WSET;
      S_WSET:   state_nx = S_STREAM;
      S_STREAM: if (hs && in_last) state_nx = S_DRAIN;
      S_DRAIN:  state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    in_ready  = 1'b0;
    pe_alu_op = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_LOAD:   begin in_ready = 1'b1; pe_alu_op = 1'b1; end
      S_WSET:   pe_alu_op = 1'b1;
      S_STREAM: in_ready = 1'b1;
      default:  ;
    endcase
  end

  // ---- lanes: pat and win shift toward lane 0, new char enters the top ----
  assign pat_nx[NUM_PE-1] = in_data;
  assign win_nx[NUM_PE-1] = in_data;

  for (genvar k = 0; k < NUM_PE; k++) begin : g_lane
    if (k < NUM_PE - 1) begin : g_shift
      assign pat_nx[k] = pat_q[k+1];
      assign win_nx[k] = win_q[k+1];
    end
    // a pattern of length plen occupies the top plen lanes
    assign active[k] = (32'(plen) + 32'(k)) >= 32'(NUM_PE);

    pe_char_feeder_lane #(.DWIDTH(DWIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .clr    ((state == S_IDLE) && start_ok),
      .ld     ((state == S_LOAD) && hs),
      .sh     ((state == S_STREAM) && hs),
      .alu_op (pe_alu_op),
      .strobe (strobe),
      .active (active[k]),
      .pat_in (pat_nx[k]),
      .win_in (win_nx[k]),
      .pat_q  (pat_q[k]),
      .win_q  (win_q[k]),
      .ch     (ch[k]),
      .en     (pe_en[k])
    );
  end

  assign pe_char = ch;

  // ---- datapath / registered pulses ----
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      plen        <= '0;
      lcnt        <= '0;
      cnt         <= '0;
      strobe      <= 1'b0;
      match_valid <= 1'b0;
      match_pos   <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= (state == S_IDLE) && start && !start_ok;
      done    <= (state == S_DONE);
      // strobe marks the cycle in which the PEs compare the freshly shifted window
      strobe  <= (state == S_STREAM) && hs;

      if ((state == S_IDLE) && start_ok) begin
        plen <= pat_len;
        lcnt <= '0;
        cnt  <= '0;
      end
      if ((state == S_LOAD) && hs)   lcnt <= lcnt + LW'(1);
      if ((state == S_STREAM) && hs) cnt  <= cnt + IDXW'(1);

      // cnt already counts the character compared this cycle; windows that are
      // not yet filled with pat_len text characters never report
      match_valid <= strobe && (&pe_match) && (cnt >= IDXW'(plen));
      if (strobe && (&pe_match) && (cnt >= IDXW'(plen)))
        match_pos <= cnt - IDXW'(plen);
    end

`ifdef PE_FEEDER_MATCH_COUNT_EN
  always_ff @(posedge clk or posedge reset)
    if (reset)
      match_count <= '0;
    else if ((state == S_IDLE) && start_ok)
      match_count <= '0;
    else if (match_valid && (match_count != '1))
      match_count <= match_count + IDXW'(1);
`endif

endmodule

// File: tb/tb_pe_char_feeder.sv
// Bench for pe_char_feeder: behavioural PE array model, randomized and directed
// jobs, scoreboard of expected match positions computed from pattern/text.
module tb_pe_char_feeder;
  localparam int DW = 8;
  localparam int NP = 8;
  localparam int IW = 16;
  localparam int LW = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start = 1'b0;
  logic [LW-1:0]     pat_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic              in_last = 1'b0;
  logic              pe_alu_op;
  logic [NP-1:0]     pe_en;
  logic [NP*DW-1:0]  pe_char;
  logic [NP-1:0]     pe_match = '1;
  logic              match_valid;
  logic [IW-1:0]     match_pos;
  logic              busy, done, cfg_err;
`ifdef PE_FEEDER_MATCH_COUNT_EN
  logic [IW-1:0]     match_count;
`endif

  always #5 clk = ~clk;

  pe_char_feeder #(.DWIDTH(DW), .NUM_PE(NP), .IDXW(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .pat_len(pat_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .pe_alu_op(pe_alu_op), .pe_en(pe_en), .pe_char(pe_char), .pe_match(pe_match),
    .match_valid(match_valid), .match_pos(match_pos),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef PE_FEEDER_MATCH_COUNT_EN
    , .match_count(match_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---- PE array model: weight latch while alu_op, compare on falling edge ----
  logic [NP-1:0][DW-1:0] w = '0;
  logic [NP-1:0][DW-1:0] chr;
  assign chr = pe_char;
  always @(negedge clk)
    for (int k = 0; k < NP; k++) begin
      if (pe_alu_op) w[k] <= chr[k];
      pe_match[k] <= !pe_en[k] || (w[k] == chr[k]);
    end

  // ---- scoreboard / monitor ----
  int            exp_q[$];
  logic [7:0]    pat[$];
  logic [7:0]    txt[$];
  logic [NP-1:0] en_mask = '0;
  logic [NP-1:0] last_en = '0;
  logic          in_text = 1'b0;
  logic          hs_q;
  int            alu_cnt = 0, mv_cnt = 0, cfg_cnt = 0;

  always @(posedge clk or posedge reset)
    if (reset) hs_q <= 1'b0;
    else       hs_q <= in_valid && in_ready && in_text;

  always @(negedge clk) begin
    if (!reset) begin
      if (pe_alu_op) alu_cnt++;
      if (cfg_err)   cfg_cnt++;
      if (pe_en != '0) last_en = pe_en;
      checks++;
      if (pe_en !== (hs_q ? en_mask : '0)) begin
        errors++;
        $display("FAIL pe_en actual=%b required=%b", pe_en, hs_q ? en_mask : '0);
      end
      if (match_valid) begin
        mv_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL match_unexpected actual_pos=%0d required=no match", match_pos);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (match_pos !== IW'(e)) begin
            errors++;
            $display("FAIL match_pos actual=%0d required=%0d", match_pos, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [127:0] v;
    v = {in_ready, pe_alu_op, pe_en, pe_char, match_valid, match_pos, busy, done, cfg_err};
`ifdef PE_FEEDER_MATCH_COUNT_EN
    v = v | 128'(match_count);
`endif
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s outputs actual=%h required=0", name, v);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    in_data = d; in_last = last; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        checks++; errors++;
        $display("FAIL ready_timeout actual=0 required=1");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic begin_job(input int plen);
    en_mask = NP'(((1 << plen) - 1) << (NP - plen));
    alu_cnt = 0; mv_cnt = 0;
    start = 1'b1; pat_len = LW'(plen);
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < plen; j++) send(pat[j], 1'b0);
  endtask

  // Expected matches straight from the definition: every text index i where
  // the plen characters starting at i equal the pattern.
  task automatic run_job(input int plen, input int gap_at, input int gap_len, input bit rgap);
    int exp_n;
    bit ok;
    exp_n = 0;
    for (int i = 0; i + plen <= txt.size(); i++) begin
      ok = 1'b1;
      for (int j = 0; j < plen; j++) if (txt[i+j] != pat[j]) ok = 1'b0;
      if (ok) begin exp_q.push_back(i); exp_n++; end
    end
    begin_job(plen);
    in_text = 1'b1;
    for (int i = 0; i < txt.size(); i++) begin
      if (i == gap_at) begin
        repeat (gap_len) @(posedge clk);
        #1;
      end else if (rgap && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send(txt[i], i == txt.size() - 1);
    end
    in_text = 1'b0;
    @(posedge clk); #1;
    chk("done_early", done, 0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1);
    chk("busy_after_done", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("done_single", done, 0);
    chk("matches_missing", exp_q.size(), 0);
    exp_q.delete();
    chk("alu_op_cycles", alu_cnt, plen + 1);
    chk("match_total", mv_cnt, exp_n);
`ifdef PE_FEEDER_MATCH_COUNT_EN
    chk("match_count", match_count, exp_n);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, plen, off;
    reset = 1'b1;
    #1;
    chk_zero("reset_state");
    #21 reset = 1'b0;
    @(posedge clk); #1;

    // directed: AB in CABAB -> 1, 3
    pat = '{8'h41, 8'h42};
    txt = '{8'h43, 8'h41, 8'h42, 8'h41, 8'h42};
    run_job(2, -1, 0, 1'b0);
    chk("pe_en_lanes", last_en, 8'hC0);

    // overlapping AA in AAAA -> 0, 1, 2
    pat = '{8'h41, 8'h41};
    txt = '{8'h41, 8'h41, 8'h41, 8'h41};
    run_job(2, -1, 0, 1'b0);

    // full width with a 3-cycle gap
    pat.delete(); txt.delete();
    for (int i = 0; i < 8; i++) begin
      pat.push_back(8'h30 + 8'(i));
      txt.push_back(8'h30 + 8'(i));
    end
    run_job(8, 4, 3, 1'b0);

    // config errors
    cfg_cnt = 0;
    for (int v = 0; v < 2; v++) begin
      start = 1'b1; pat_len = (v == 0) ? 4'd0 : 4'd9;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("cfgerr_busy", busy, 0);
        chk("cfgerr_in_ready", in_ready, 0);
      end
      @(posedge clk); #1;
    end
    chk("cfg_err_pulses", cfg_cnt, 2);

    // reset in the middle of the text stream
    pat = '{8'h10, 8'h20, 8'h30};
    begin_job(3);
    in_text = 1'b1;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    #2 reset = 1'b1;
    #1 chk_zero("reset_midstream");
    exp_q.delete();
    in_text = 1'b0;
    #3 reset = 1'b0;
    @(posedge clk); #1;
    pat = '{8'h5A};
    txt = '{8'h5A};
    run_job(1, -1, 0, 1'b0);

    // randomized jobs over a two-letter alphabet
    for (int r = 0; r < 16; r++) begin
      plen = $urandom_range(1, NP);
      n = $urandom_range(1, 24);
      pat.delete(); txt.delete();
      for (int j = 0; j < plen; j++) pat.push_back(8'h41 + 8'($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) txt.push_back(8'h41 + 8'($urandom_range(0, 1)));
      if (n >= plen && $urandom_range(0, 1) == 1) begin
        off = $urandom_range(0, n - plen);
        for (int j = 0; j < plen; j++) txt[off+j] = pat[j];
      end
      run_job(plen, -1, 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
